multicycle_ctrl: RTL and testbench

- Multicycle control sequencer for the MIPS datapath: regFile, ALU, ALUControl, the RegDst/ALUSrc/MemtoReg/Jump muxes, and a single shared instruction/data memory.
- Replaces the single-cycle opcode decode with a state machine that splits each instruction into 3-5 steps.
- Drives every datapath enable and mux select from the instruction-register opcode, ALU zero flag and memory ready handshake.

---
 rtl/multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer: splits each instruction into 3-5 steps and drives datapath enables/selects.
// Optional feature macro: MULTICYCLE_CTRL_JUMP_EN (adds the JUMP state for opcode 000010).
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC_R   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_ADDI_EX  = 4'd10;
  localparam logic [3:0] S_ADDI_WB  = 4'd11;
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam logic [3:0] S_JUMP     = 4'd12;
  localparam logic [5:0] OP_J       = 6'b000010;
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       mem_state;
  logic       timeout;
  logic       illegal_dec;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Abort on the stall cycle that would bring the counter to MEM_WAIT_MAX.
  assign timeout   = mem_state && !mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    illegal_dec = 1'b1;
    if (state_q == S_DECODE) begin
      case (opcode)
        OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: illegal_dec = 1'b0;
`ifdef MULTICYCLE_CTRL_JUMP_EN
        OP_J:                                illegal_dec = 1'b0;
`endif
        default:                             illegal_dec = 1'b1;
      endcase
    end else begin
      illegal_dec = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q | illegal_dec;
    timeout_d = timeout_q | timeout;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = (mem_ready && !timeout) ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
`ifdef MULTICYCLE_CTRL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (timeout)        state_d = S_FETCH;
        else if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB:  state_d = S_FETCH;
      S_MEM_WR:  if (timeout || mem_ready) state_d = S_FETCH;
      S_EXEC_R:  state_d = S_R_WB;
      S_R_WB:    state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ADDI_WB: state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
      S_JUMP:    state_d = S_FETCH;
`endif
      default:   state_d = S_IDLE;
    endcase

    // A timed-out FETCH loops back to itself, so state change alone cannot restart the counter.
    wait_d = wait_q;
    if (timeout || (state_d != state_q)) wait_d = 8'd0;
    else if (mem_state && !mem_ready)    wait_d = wait_q + 8'd1;
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        instr_done = illegal_dec;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = !timeout;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_source  = 2'b01;
        pc_write   = alu_zero;
        instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_JUMP_EN
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs driven and outputs checked around the falling edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op, mem_timeout;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, settle.
  task automatic next(input logic mr, input logic [5:0] op, input logic az);
    @(negedge clk);
    mem_ready = mr;
    opcode    = op;
    alu_zero  = az;
    #1;
  endtask

  logic [15:0] all_outs;
  assign all_outs = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done};

  initial begin
    rst_n = 1'b0; opcode = 6'd0; alu_zero = 1'b0; mem_ready = 1'b0;
    #1;
    chk("reset_state", state, 4'd0);
    chk("reset_outs", all_outs, 16'd0);
    chk("reset_flags", {illegal_op, mem_timeout}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_after_release", state, 4'd0);

    // lw, mem_ready held high
    next(1'b1, 6'b100011, 1'b0);
    chk("lw_c1_state", state, 4'd1);
    chk("lw_c1_fetch", {mem_read, ir_write, pc_write, alu_src_b, instr_done}, 6'b111_01_0);
    next(1'b1, 6'b100011, 1'b0);
    chk("lw_c2_state", state, 4'd2);
    chk("lw_c2_outs", {mem_read, alu_src_b, instr_done}, 4'b0_11_0);
    next(1'b1, 6'b100011, 1'b0);
    chk("lw_c3_state", state, 4'd3);
    chk("lw_c3_outs", {alu_src_a, alu_src_b, mem_read}, 4'b1_10_0);
    next(1'b1, 6'b100011, 1'b0);
    chk("lw_c4_state", state, 4'd4);
    chk("lw_c4_outs", {mem_read, i_or_d, instr_done}, 3'b110);
    next(1'b1, 6'b100011, 1'b0);
    chk("lw_c5_state", state, 4'd5);
    chk("lw_c5_outs", {reg_write, mem_to_reg, reg_dst, instr_done, mem_read}, 5'b11010);

    // beq taken
    next(1'b1, 6'b000100, 1'b1);
    chk("beqT_fetch", state, 4'd1);
    next(1'b1, 6'b000100, 1'b1);
    chk("beqT_decode", state, 4'd2);
    next(1'b1, 6'b000100, 1'b1);
    chk("beqT_state", state, 4'd9);
    chk("beqT_outs", {pc_write, pc_source, alu_op, alu_src_a, alu_src_b, instr_done}, 9'b1_01_01_1_00_1);

    // beq not taken
    next(1'b1, 6'b000100, 1'b0);
    chk("beqN_fetch", state, 4'd1);
    next(1'b1, 6'b000100, 1'b0);
    next(1'b1, 6'b000100, 1'b0);
    chk("beqN_state", state, 4'd9);
    chk("beqN_outs", {pc_write, pc_source, instr_done}, 4'b0_01_1);

    // sw with three stall cycles
    next(1'b1, 6'b101011, 1'b0);
    chk("sw_fetch", state, 4'd1);
    next(1'b1, 6'b101011, 1'b0);
    next(1'b1, 6'b101011, 1'b0);
    chk("sw_addr", state, 4'd3);
    for (int i = 0; i < 3; i++) begin
      next(1'b0, 6'b101011, 1'b0);
      chk("sw_stall_state", state, 4'd6);
      chk("sw_stall_outs", {mem_write, i_or_d, instr_done}, 3'b110);
    end
    next(1'b1, 6'b101011, 1'b0);
    chk("sw_done_state", state, 4'd6);
    chk("sw_done_outs", {mem_write, i_or_d, instr_done}, 3'b111);

    // R-type
    next(1'b1, 6'b000000, 1'b0);
    chk("r_fetch", state, 4'd1);
    chk("sw_no_timeout", mem_timeout, 1'b0);
    next(1'b1, 6'b000000, 1'b0);
    next(1'b1, 6'b000000, 1'b0);
    chk("r_exec_state", state, 4'd7);
    chk("r_exec_outs", {alu_src_a, alu_src_b, alu_op}, 5'b1_00_10);
    next(1'b1, 6'b000000, 1'b0);
    chk("r_wb_state", state, 4'd8);
    chk("r_wb_outs", {reg_write, reg_dst, mem_to_reg, instr_done}, 4'b1101);

    // addi
    next(1'b1, 6'b001000, 1'b0);
    chk("addi_fetch", state, 4'd1);
    next(1'b1, 6'b001000, 1'b0);
    next(1'b1, 6'b001000, 1'b0);
    chk("addi_ex_state", state, 4'd10);
    chk("addi_ex_outs", {alu_src_a, alu_src_b, alu_op}, 5'b1_10_00);
    next(1'b1, 6'b001000, 1'b0);
    chk("addi_wb_state", state, 4'd11);
    chk("addi_wb_outs", {reg_write, reg_dst, mem_to_reg, instr_done}, 4'b1001);

    // illegal opcode 111111
    next(1'b1, 6'b111111, 1'b0);
    chk("ill_fetch", state, 4'd1);
    next(1'b1, 6'b111111, 1'b0);
    chk("ill_decode_state", state, 4'd2);
    chk("ill_decode_done", instr_done, 1'b1);
    chk("ill_not_yet", illegal_op, 1'b0);
    next(1'b1, 6'b111111, 1'b0);
    chk("ill_next_fetch", state, 4'd1);
    chk("ill_sticky", illegal_op, 1'b1);
    chk("ill_done_cleared", instr_done, 1'b0);

    // asynchronous reset in the middle of a lw memory read
    next(1'b1, 6'b100011, 1'b0);
    next(1'b1, 6'b100011, 1'b0);
    next(1'b0, 6'b100011, 1'b0);
    chk("rst_pre_state", state, 4'd4);
    chk("rst_pre_read", mem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_state", state, 4'd0);
    chk("rst_async_outs", all_outs, 16'd0);
    chk("rst_async_flags", {illegal_op, mem_timeout}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_idle", state, 4'd0);

    // timeout in FETCH with MEM_WAIT_MAX=4
    for (int i = 0; i < 4; i++) begin
      next(1'b0, 6'b000000, 1'b0);
      chk("to_fetch_state", state, 4'd1);
      chk("to_no_writes", {ir_write, pc_write, mem_timeout}, 3'b000);
    end
    next(1'b0, 6'b000000, 1'b0);
    chk("to_refetch", state, 4'd1);
    chk("to_flag", mem_timeout, 1'b1);
    chk("to_no_writes_after", {ir_write, pc_write, instr_done}, 3'b000);

    // opcode 000010
    next(1'b1, 6'b000010, 1'b0);
    chk("j_fetch", state, 4'd1);
    next(1'b1, 6'b000010, 1'b0);
    chk("j_decode", state, 4'd2);
`ifdef MULTICYCLE_CTRL_JUMP_EN
    chk("j_decode_done", instr_done, 1'b0);
    next(1'b1, 6'b000010, 1'b0);
    chk("j_state", state, 4'd12);
    chk("j_outs", {pc_write, pc_source, instr_done}, 4'b1_10_1);
    next(1'b1, 6'b000010, 1'b0);
    chk("j_back_fetch", state, 4'd1);
    chk("j_legal", illegal_op, 1'b0);
`else
    chk("j_ill_done", instr_done, 1'b1);
    next(1'b1, 6'b000010, 1'b0);
    chk("j_ill_fetch", state, 4'd1);
    chk("j_ill_sticky", illegal_op, 1'b1);
`endif
    chk("timeout_still_sticky", mem_timeout, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
